// File: rtl/mux4_rr_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// mux4_rr_arbiter_pkg
// Shared definitions for the four-way round-robin mux arbiter:
//   - arb_state_e      : arbiter state encoding (idle / grant)
//   - REQ_A .. REQ_D   : requester index constants, also the mux select codes
//   - PTR_RESET        : rotation pointer value after reset (requester 0 first)
//   - idx_to_onehot()  : requester index -> one-hot grant vector
// ---------------------------------------------------------------------------
package mux4_rr_arbiter_pkg;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_GRANT = 1'b1
    } arb_state_e;

    localparam logic [1:0] REQ_A = 2'd0;
    localparam logic [1:0] REQ_B = 2'd1;
    localparam logic [1:0] REQ_C = 2'd2;
    localparam logic [1:0] REQ_D = 2'd3;

    // Pointing at the last requester makes requester 0 the first one scanned.
    localparam logic [1:0] PTR_RESET = REQ_D;

    function automatic logic [3:0] idx_to_onehot(input logic [1:0] idx);
        logic [3:0] oh_v;
        oh_v = 4'b0000;
        case (idx)
            REQ_A:   oh_v = 4'b0001;
            REQ_B:   oh_v = 4'b0010;
            REQ_C:   oh_v = 4'b0100;
            REQ_D:   oh_v = 4'b1000;
            default: oh_v = 4'b0000;
        endcase
        return oh_v;
    endfunction

endpackage

// File: rtl/mux4_1.sv
// ---------------------------------------------------------------------------
// mux4_1
// Single-bit 4:1 steering mux, the building block replicated per data bit.
// Ports:
//   d0..d3  in  1  data inputs for select codes REQ_A..REQ_D
//   sel     in  2  select code
//   y       out 1  selected input
// ---------------------------------------------------------------------------
module mux4_1
    import mux4_rr_arbiter_pkg::*;
(
    input  logic       d0,
    input  logic       d1,
    input  logic       d2,
    input  logic       d3,
    input  logic [1:0] sel,
    output logic       y
);

    // Steer one of the four inputs to the output.
    always_comb begin
        y = 1'b0;
        case (sel)
            REQ_A:   y = d0;
            REQ_B:   y = d1;
            REQ_C:   y = d2;
            REQ_D:   y = d3;
            default: y = 1'b0;
        endcase
    end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// ---------------------------------------------------------------------------
// mux4_rr_arbiter
// Round-robin arbiter sharing one 4:1 steering mux among four requesters.
// One requester holds the grant at a time; when it releases its request the
// next requester (scanning upward from the holder, with wrap-around) is
// granted on the same edge, so there is no idle bubble between grants.
//
// Optional feature (macro ARB_TIMEOUT_EN): a holder that keeps its request
// for MAX_HOLD consecutive cycles is pre-empted if anyone else is waiting.
// Without the macro the holder keeps the grant for as long as it requests,
// and the hold counter and MAX_HOLD parameter do not exist.
//
// Parameters:
//   DATA_W    width of each data word and of data_out
//   MAX_HOLD  max consecutive grant cycles per holder (ARB_TIMEOUT_EN only, >=2)
// Ports:
//   clk       in   1       rising-edge clock
//   rst_n     in   1       asynchronous active-low reset
//   req       in   4       level-held request per requester
//   data_a..d in   DATA_W  requester 0..3 data
//   gnt       out  4       one-hot grant (registered), zero when idle
//   sel       out  2       index of current/last holder (registered)
//   valid     out  1       grant active (registered)
//   data_out  out  DATA_W  selected data while valid, else zero
// ---------------------------------------------------------------------------
module mux4_rr_arbiter
    import mux4_rr_arbiter_pkg::*;
#(
    parameter int DATA_W   = 32
`ifdef ARB_TIMEOUT_EN
    ,
    parameter int MAX_HOLD = 8
`endif
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [3:0]        req,
    input  logic [DATA_W-1:0] data_a,
    input  logic [DATA_W-1:0] data_b,
    input  logic [DATA_W-1:0] data_c,
    input  logic [DATA_W-1:0] data_d,
    output logic [3:0]        gnt,
    output logic [1:0]        sel,
    output logic              valid,
    output logic [DATA_W-1:0] data_out
);

    // Winner = first set request bit scanning ptr+1, ptr+2, ptr+3, ptr+4
    // (mod 4). The last candidate is the pointer itself, so a lone request
    // from the previous holder is still found. Caller checks |r first.
    function automatic logic [1:0] pick_winner(input logic [3:0] r,
                                               input logic [1:0] ptr);
        logic [1:0] win_v;
        logic [1:0] cand_v;
        logic       found_v;
        win_v   = ptr;
        cand_v  = ptr;
        found_v = 1'b0;
        for (int unsigned k = 32'd1; k <= 32'd4; k++) begin
            cand_v = ptr + k[1:0];
            if (!found_v && r[cand_v]) begin
                win_v   = cand_v;
                found_v = 1'b1;
            end else begin
                win_v   = win_v;
            end
        end
        return win_v;
    endfunction

    arb_state_e        state_r;
    arb_state_e        state_s;
    logic [3:0]        gnt_r;
    logic [3:0]        gnt_s;
    logic [1:0]        sel_r;
    logic [1:0]        sel_s;
    logic              valid_r;
    logic              valid_s;
    logic [1:0]        last_r;
    logic [1:0]        last_s;
    logic [1:0]        arb_win_s;
    logic [DATA_W-1:0] mux_s;

`ifdef ARB_TIMEOUT_EN
    localparam int                HOLD_W    = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);
    localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);
    localparam logic [HOLD_W-1:0] HOLD_ZERO = HOLD_W'(0);

    logic [HOLD_W-1:0] hold_cnt_r;
    logic [HOLD_W-1:0] hold_cnt_s;
    logic [3:0]        others_s;
    logic [1:0]        other_win_s;

    // Requesters other than the current holder, and who among them is next.
    always_comb begin
        others_s    = req & ~gnt_r;
        other_win_s = pick_winner(others_s, last_r);
    end
`endif

    // Normal rotation winner; pointer is the last granted requester.
    always_comb begin
        arb_win_s = pick_winner(req, last_r);
    end

    // Next-state and next-output logic of the arbitration FSM.
    always_comb begin
        state_s = state_r;
        gnt_s   = gnt_r;
        sel_s   = sel_r;
        valid_s = valid_r;
        last_s  = last_r;
`ifdef ARB_TIMEOUT_EN
        hold_cnt_s = hold_cnt_r;
`endif
        case (state_r)
            ARB_IDLE: begin
                if (|req) begin
                    state_s = ARB_GRANT;
                    gnt_s   = idx_to_onehot(arb_win_s);
                    sel_s   = arb_win_s;
                    valid_s = 1'b1;
                    last_s  = arb_win_s;
`ifdef ARB_TIMEOUT_EN
                    hold_cnt_s = HOLD_ZERO;
`endif
                end else begin
                    state_s = ARB_IDLE;
                end
            end
            ARB_GRANT: begin
                if (req[sel_r]) begin
`ifdef ARB_TIMEOUT_EN
                    // Pre-empt only when someone else is actually waiting.
                    if ((hold_cnt_r == HOLD_LAST) && (|others_s)) begin
                        gnt_s      = idx_to_onehot(other_win_s);
                        sel_s      = other_win_s;
                        last_s     = other_win_s;
                        hold_cnt_s = HOLD_ZERO;
                    end else if (hold_cnt_r != HOLD_LAST) begin
                        hold_cnt_s = hold_cnt_r + HOLD_ONE;
                    end else begin
                        hold_cnt_s = hold_cnt_r;
                    end
`else
                    state_s = ARB_GRANT;
`endif
                end else if (|req) begin
                    // Holder's own bit is low, so it cannot win here.
                    gnt_s   = idx_to_onehot(arb_win_s);
                    sel_s   = arb_win_s;
                    last_s  = arb_win_s;
`ifdef ARB_TIMEOUT_EN
                    hold_cnt_s = HOLD_ZERO;
`endif
                end else begin
                    // Nobody left: drop the grant but keep sel at the old holder.
                    state_s = ARB_IDLE;
                    gnt_s   = 4'b0000;
                    valid_s = 1'b0;
`ifdef ARB_TIMEOUT_EN
                    hold_cnt_s = HOLD_ZERO;
`endif
                end
            end
            default: begin
                state_s = ARB_IDLE;
                gnt_s   = 4'b0000;
                valid_s = 1'b0;
            end
        endcase
    end

    // Arbiter state and output registers; reset clears the grant at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ARB_IDLE;
            gnt_r   <= 4'b0000;
            sel_r   <= REQ_A;
            valid_r <= 1'b0;
            last_r  <= PTR_RESET;
        end else begin
            state_r <= state_s;
            gnt_r   <= gnt_s;
            sel_r   <= sel_s;
            valid_r <= valid_s;
            last_r  <= last_s;
        end
    end

`ifdef ARB_TIMEOUT_EN
    // Consecutive-cycle counter for the current holder, saturating.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_cnt_r <= HOLD_ZERO;
        end else begin
            hold_cnt_r <= hold_cnt_s;
        end
    end
`endif

    // One 4:1 mux per data bit, all steered by the registered select.
    for (genvar b = 0; b < DATA_W; b++) begin : g_bit_mux
        mux4_1 u_mux4_1 (
            .d0  (data_a[b]),
            .d1  (data_b[b]),
            .d2  (data_c[b]),
            .d3  (data_d[b]),
            .sel (sel_r),
            .y   (mux_s[b])
        );
    end

    assign data_out = mux_s & {DATA_W{valid_r}};
    assign gnt      = gnt_r;
    assign sel      = sel_r;
    assign valid    = valid_r;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mux4_rr_arbiter
// Directed scenarios followed by a randomized phase, every cycle compared
// against a behavioural model of the round-robin rules (holder index,
// rotation pointer and consecutive-hold count kept as plain integers).
// ---------------------------------------------------------------------------
module tb_mux4_rr_arbiter;

    localparam int DATA_W   = 32;
    localparam int MAX_HOLD = 4;

    logic              clk;
    logic              rst_n;
    logic [3:0]        req;
    logic [DATA_W-1:0] data_a;
    logic [DATA_W-1:0] data_b;
    logic [DATA_W-1:0] data_c;
    logic [DATA_W-1:0] data_d;
    logic [3:0]        gnt;
    logic [1:0]        sel;
    logic              valid;
    logic [DATA_W-1:0] data_out;

    int checks = 0;
    int errors = 0;

    // Model: m_valid (grant active), m_sel (holder / last select),
    // m_last (rotation pointer), m_hold (consecutive cycles held - 1).
    bit m_valid;
    int m_sel;
    int m_last;
    int m_hold;

`ifdef ARB_TIMEOUT_EN
    mux4_rr_arbiter #(.DATA_W(DATA_W), .MAX_HOLD(MAX_HOLD)) dut (
`else
    mux4_rr_arbiter #(.DATA_W(DATA_W)) dut (
`endif
        .clk(clk), .rst_n(rst_n), .req(req),
        .data_a(data_a), .data_b(data_b), .data_c(data_c), .data_d(data_d),
        .gnt(gnt), .sel(sel), .valid(valid), .data_out(data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int winner(input logic [3:0] r, input int ptr);
        for (int k = 1; k <= 4; k++) begin
            if (r[(ptr + k) % 4]) return (ptr + k) % 4;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_valid = 1'b0;
        m_sel   = 0;
        m_last  = 3;
        m_hold  = 0;
    endtask

    task automatic model_grant(input int w);
        m_valid = 1'b1;
        m_sel   = w;
        m_last  = w;
        m_hold  = 0;
    endtask

    // Apply the arbitration rules to the request vector seen at an edge.
    task automatic model_edge(input logic [3:0] r);
        logic [3:0] others;
        if (!m_valid) begin
            if (r != 4'b0000) model_grant(winner(r, m_last));
        end else if (r[m_sel]) begin
            others = r;
            others[m_sel] = 1'b0;
`ifdef ARB_TIMEOUT_EN
            if (m_hold == MAX_HOLD - 1 && others != 4'b0000)
                model_grant(winner(others, m_sel));
            else if (m_hold < MAX_HOLD - 1)
                m_hold++;
`endif
        end else if (r != 4'b0000) begin
            model_grant(winner(r, m_sel));
        end else begin
            m_valid = 1'b0;
        end
    endtask

    task automatic check_all(input string tag);
        logic [3:0]        e_gnt;
        logic [1:0]        e_sel;
        logic [DATA_W-1:0] e_data;
        e_gnt = m_valid ? 4'(1 << m_sel) : 4'b0000;
        e_sel = 2'(m_sel);
        case (m_sel)
            0:       e_data = data_a;
            1:       e_data = data_b;
            2:       e_data = data_c;
            default: e_data = data_d;
        endcase
        if (!m_valid) e_data = '0;
        checks++;
        assert (gnt === e_gnt) else begin
            errors++; $error("FAIL %s gnt observed=%b expected=%b", tag, gnt, e_gnt);
        end
        checks++;
        assert (sel === e_sel) else begin
            errors++; $error("FAIL %s sel observed=%0d expected=%0d", tag, sel, e_sel);
        end
        checks++;
        assert (valid === m_valid) else begin
            errors++; $error("FAIL %s valid observed=%b expected=%b", tag, valid, m_valid);
        end
        checks++;
        assert (data_out === e_data) else begin
            errors++; $error("FAIL %s data_out observed=%h expected=%h", tag, data_out, e_data);
        end
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        model_edge(req);
        #1;
        check_all(tag);
    endtask

    task automatic expect_gnt(input string tag, input logic [3:0] exp);
        checks++;
        assert (gnt === exp) else begin
            errors++; $error("FAIL %s gnt observed=%b expected=%b", tag, gnt, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        req   = 4'b0000;
        model_reset();
        #1;
        check_all("reset");
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n  = 1'b1;
        req    = 4'b0000;
        data_a = 32'hDEADBEEF;
        data_b = 32'h1111_2222;
        data_c = 32'h3333_4444;
        data_d = 32'h5555_6666;
        model_reset();

        // 1: single request from reset, one-cycle latency
        do_reset();
        req = 4'b0001;
        step("t1_grant");
        expect_gnt("t1_gnt", 4'b0001);
        checks++;
        assert (data_out === 32'hDEADBEEF) else begin
            errors++; $error("FAIL t1_data observed=%h expected=%h", data_out, 32'hDEADBEEF);
        end

        // 2: all request, each holder releases after two cycles
        do_reset();
        req = 4'b1111;
        for (int g = 0; g < 4; g++) begin
            step("t2_first");
            expect_gnt("t2_order", 4'(1 << g));
            step("t2_second");
            expect_gnt("t2_hold", 4'(1 << g));
            req[g] = 1'b0;
        end
        step("t2_idle");
        expect_gnt("t2_idle_gnt", 4'b0000);

        // 3: holder 2 keeps its request while 0 and 1 wait
        req = 4'b0100;
        step("t3_grant");
        req = 4'b0111;
        for (int i = 0; i < 20; i++) begin
            step("t3_hold");
`ifndef ARB_TIMEOUT_EN
            expect_gnt("t3_no_timeout", 4'b0100);
`endif
        end
        req = 4'b0000;
        step("t3_release");
        step("t3_idle");

        // 4: holder 1 drops with 0 and 3 pending -> 3, then 0
        do_reset();
        req = 4'b0010;
        step("t4_grant1");
        expect_gnt("t4_holder1", 4'b0010);
        req = 4'b1011;
        step("t4_hold");
        req = 4'b1001;
        step("t4_to3");
        expect_gnt("t4_next3", 4'b1000);
        req = 4'b0001;
        step("t4_to0");
        expect_gnt("t4_next0", 4'b0001);

`ifdef ARB_TIMEOUT_EN
        // 5: holder 0 pre-empted after MAX_HOLD cycles
        do_reset();
        req = 4'b0011;
        for (int i = 0; i < MAX_HOLD; i++) begin
            step("t5_hold");
            expect_gnt("t5_hold_gnt", 4'b0001);
        end
        step("t5_preempt");
        expect_gnt("t5_preempt_gnt", 4'b0010);
`endif

        // 6: asynchronous reset in the middle of a grant
        do_reset();
        req = 4'b1000;
        step("t6_grant");
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all("t6_async_reset");
        #2;
        rst_n = 1'b1;
        req = 4'b0110;
        step("t6_after");
        expect_gnt("t6_lowest", 4'b0010);

        // Random phase: requests change now and then, data every cycle
        do_reset();
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) req = 4'($urandom_range(0, 15));
            data_a = $urandom();
            data_b = $urandom();
            data_c = $urandom();
            data_d = $urandom();
            step("random");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
